regfile_wb_arbiter: RTL and testbench



---
 rtl/wb_pkg.sv | 23 ++
 rtl/wb_fifo.sv | 56 +++++
 rtl/regfile_wb_arbiter.sv | 116 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the register file writeback path.
package wb_pkg;

  localparam int NSRC_DEF = 4;
  localparam int RADDR_W  = 5;
  localparam int DATA_W   = 32;
  localparam int NREG     = 1 << RADDR_W;

  localparam int SRC_ALU = 0;
  localparam int SRC_MDU = 1;
  localparam int SRC_LSU = 2;
  localparam int SRC_CP0 = 3;

  typedef struct packed {
    logic [RADDR_W-1:0] addr;
    logic [DATA_W-1:0]  data;
  } wb_req_t;

  function automatic logic [NREG-1:0] reg_onehot(input logic [RADDR_W-1:0] a);
    return NREG'(1) << a;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-source in-order writeback FIFO; head visible same cycle it is written-through-registered (1-cycle fill latency).
// No internal backpressure: caller gates push on count < DEPTH and pop on count != 0; flush empties it at the next edge.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  wb_req_t                  din_i,
  output wb_req_t                  dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [NREG-1:0]          addr_mask_o
);

  localparam int PW = $clog2(DEPTH);

  wb_req_t         mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [PW:0]     count_q;
  logic [PW-1:0]   off;

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    addr_mask_o = '0;
    off         = '0;
    for (int j = 0; j < DEPTH; j++) begin
      off = PW'(j) - rd_ptr_q;
      if ((PW+1)'(off) < count_q) addr_mask_o = addr_mask_o | reg_onehot(mem_q[j].addr);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin merge of NSRC writeback FIFOs onto the single register file write port; accept to rf_we is 2 cycles.
// Per-source ready drops when that FIFO is full (registered count only); flush drops everything buffered or staged.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int NSRC  = NSRC_DEF,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NSRC-1:0]           src_valid,
  output logic [NSRC-1:0]           src_ready,
  input  logic [NSRC*RADDR_W-1:0]   src_addr,
  input  logic [NSRC*DATA_W-1:0]    src_data,
  input  logic                      flush,
  output logic                      rf_we,
  output logic [RADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic [NREG-1:0]           pend_mask,
  output logic                      idle
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int RRW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [CW-1:0]   count    [NSRC];
  wb_req_t         head     [NSRC];
  logic [NREG-1:0] fmask    [NSRC];
  logic [NSRC-1:0] push;
  logic [NSRC-1:0] pop;
  logic [NSRC-1:0] nonempty;

  logic            grant_vld;
  logic [RRW-1:0]  grant_idx;
  logic [RRW-1:0]  cand;
  logic [RRW-1:0]  rr_q, rr_d;

  logic               rf_we_q, rf_we_d;
  logic [RADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]  rf_wdata_q, rf_wdata_d;

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    wb_req_t req_in;

    assign req_in.addr   = src_addr[gi*RADDR_W +: RADDR_W];
    assign req_in.data   = src_data[gi*DATA_W +: DATA_W];
    assign src_ready[gi] = rst_n && (count[gi] < CW'(DEPTH));
    // $0 writes are handshaken but never stored.
    assign push[gi]      = src_valid[gi] && src_ready[gi] && (req_in.addr != '0);
    assign nonempty[gi]  = (count[gi] != '0);
    assign pop[gi]       = grant_vld && (grant_idx == RRW'(gi));

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush),
      .push_i      (push[gi]),
      .pop_i       (pop[gi]),
      .din_i       (req_in),
      .dout_o      (head[gi]),
      .count_o     (count[gi]),
      .addr_mask_o (fmask[gi])
    );
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NSRC; k++) begin
      cand = RRW'((int'(rr_q) + k) % NSRC);
      if (!grant_vld && nonempty[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    rr_d       = rr_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (grant_vld && !flush) begin
      rr_d       = RRW'((int'(grant_idx) + 1) % NSRC);
      rf_we_d    = 1'b1;
      rf_waddr_d = head[grant_idx].addr;
      rf_wdata_d = head[grant_idx].data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q       <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rr_q       <= rr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  always_comb begin
    pend_mask = rf_we_q ? reg_onehot(rf_waddr_q) : '0;
    for (int i = 0; i < NSRC; i++) pend_mask = pend_mask | fmask[i];
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign idle     = ~|nonempty && !rf_we_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, latency, round-robin, backpressure, $0 drop, flush.
module tb_regfile_wb_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   src_valid;
  logic [3:0]   src_ready;
  logic [19:0]  src_addr;
  logic [127:0] src_data;
  logic         flush;
  logic         rf_we;
  logic [4:0]   rf_waddr;
  logic [31:0]  rf_wdata;
  logic [31:0]  pend_mask;
  logic         idle;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.NSRC(4), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_addr  (src_addr),
    .src_data  (src_data),
    .flush     (flush),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .pend_mask (pend_mask),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    src_valid = '0;
    src_addr  = '0;
    src_data  = '0;
    flush     = 1'b0;
  endtask

  task automatic drive(input int i, input logic [4:0] a, input logic [31:0] d);
    src_valid[i]        = 1'b1;
    src_addr[i*5 +: 5]  = a;
    src_data[i*32 +: 32] = d;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    src_valid = 4'hF;
    src_addr  = {5'd4, 5'd3, 5'd2, 5'd1};
    step();
    step();
    checks++; if (src_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", src_ready); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", rf_we); end
    checks++; if (pend_mask !== 32'h0) begin errors++; $display("FAIL reset_pend: got %h expected 0", pend_mask); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", idle); end
    checks++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'h0) begin errors++; $display("FAIL reset_addr_data: got %0d/%h expected 0/0", rf_waddr, rf_wdata); end
    rst_n = 1'b1;
    clear_inputs();
    step();
    checks++; if (src_ready !== 4'b1111) begin errors++; $display("FAIL ready_after_reset: got %b expected 1111", src_ready); end
  endtask

  task automatic test_single_write();
    drive(0, 5'd5, 32'h1234_5678);
    step();
    clear_inputs();
    checks++; if (pend_mask !== 32'h20 || rf_we !== 1'b0) begin errors++; $display("FAIL single_n1: pend %h we %b expected 00000020 0", pend_mask, rf_we); end
    step();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234_5678) begin errors++; $display("FAIL single_write: we %b addr %0d data %h expected 1 5 12345678", rf_we, rf_waddr, rf_wdata); end
    checks++; if (pend_mask !== 32'h20) begin errors++; $display("FAIL single_n2_pend: got %h expected 00000020", pend_mask); end
    step();
    checks++; if (pend_mask !== 32'h0 || idle !== 1'b1 || rf_we !== 1'b0) begin errors++; $display("FAIL single_n3: pend %h idle %b we %b expected 0 1 0", pend_mask, idle, rf_we); end
  endtask

  task automatic test_all_sources();
    do_reset();
    for (int i = 0; i < 4; i++) drive(i, 5'(i + 1), 32'hA0 + i);
    step();
    clear_inputs();
    checks++; if (pend_mask !== 32'h1E) begin errors++; $display("FAIL all_pend: got %h expected 0000001e", pend_mask); end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'(k + 1) || rf_wdata !== 32'hA0 + k) begin
        errors++;
        $display("FAIL all_order[%0d]: we %b addr %0d data %h expected 1 %0d %h", k, rf_we, rf_waddr, rf_wdata, k + 1, 32'hA0 + k);
      end
    end
    step();
    checks++; if (rf_we !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL all_drained: we %b idle %b expected 0 1", rf_we, idle); end
    checks++; if (dut.rr_q !== 2'd0) begin errors++; $display("FAIL all_rr: got %0d expected 0", dut.rr_q); end
  endtask

  // ALU/LSU/CP0 hold one entry each so the MDU FIFO can fill while waiting its turn.
  task automatic test_mdu_backpressure();
    int ewe [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
    int ea  [9] = '{0, 0, 10, 7, 11, 12, 7, 8, 0};
    int ed  [9] = '{0, 0, 'hA, 1, 'hB, 'hC, 2, 3, 0};
    int ep7 [9] = '{0, 1, 1, 1, 1, 1, 1, 0, 0};
    do_reset();
    for (int c = 0; c < 9; c++) begin
      checks++;
      if (rf_we !== 1'(ewe[c])) begin errors++; $display("FAIL mdu_we[%0d]: got %b expected %0d", c, rf_we, ewe[c]); end
      if (ewe[c] != 0) begin
        checks++;
        if (rf_waddr !== 5'(ea[c]) || rf_wdata !== 32'(ed[c])) begin
          errors++;
          $display("FAIL mdu_write[%0d]: addr %0d data %h expected %0d %h", c, rf_waddr, rf_wdata, ea[c], ed[c]);
        end
      end
      checks++;
      if (pend_mask[7] !== 1'(ep7[c])) begin errors++; $display("FAIL mdu_pend7[%0d]: got %b expected %0d", c, pend_mask[7], ep7[c]); end
      case (c)
        0: begin
          drive(0, 5'd10, 32'hA);
          drive(1, 5'd7, 32'd1);
          drive(2, 5'd11, 32'hB);
          drive(3, 5'd12, 32'hC);
        end
        1: begin
          clear_inputs();
          drive(1, 5'd7, 32'd2);
        end
        2: begin
          checks++; if (src_ready[1] !== 1'b0) begin errors++; $display("FAIL mdu_full_ready: got %b expected 0", src_ready[1]); end
          clear_inputs();
          drive(1, 5'd8, 32'd3);
        end
        3: begin
          checks++; if (src_ready[1] !== 1'b1) begin errors++; $display("FAIL mdu_reopen_ready: got %b expected 1", src_ready[1]); end
        end
        default: clear_inputs();
      endcase
      step();
    end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL mdu_idle: got %b expected 1", idle); end
  endtask

  task automatic test_zero_write();
    drive(2, 5'd0, 32'hFFFF_FFFF);
    checks++; if (src_ready[2] !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b expected 1", src_ready[2]); end
    step();
    clear_inputs();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (rf_we !== 1'b0 || pend_mask !== 32'h0 || idle !== 1'b1) begin
        errors++;
        $display("FAIL zero_drop[%0d]: we %b pend %h idle %b expected 0 0 1", c, rf_we, pend_mask, idle);
      end
      step();
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(0, 5'd3, 32'h33);
    drive(1, 5'd4, 32'h44);
    drive(2, 5'd5, 32'h55);
    step();
    clear_inputs();
    checks++; if (pend_mask !== 32'h38) begin errors++; $display("FAIL flush_pre_pend: got %h expected 00000038", pend_mask); end
    flush = 1'b1;
    drive(0, 5'd6, 32'h66);
    step();
    clear_inputs();
    checks++; if (idle !== 1'b1 || pend_mask !== 32'h0 || rf_we !== 1'b0) begin errors++; $display("FAIL flush_clear: idle %b pend %h we %b expected 1 0 0", idle, pend_mask, rf_we); end
    checks++; if (dut.rr_q !== 2'd0) begin errors++; $display("FAIL flush_rr: got %0d expected 0", dut.rr_q); end
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (rf_we !== 1'b0 || pend_mask !== 32'h0) begin errors++; $display("FAIL flush_quiet[%0d]: we %b pend %h expected 0 0", c, rf_we, pend_mask); end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_write();
    test_all_sources();
    test_mdu_backpressure();
    test_zero_write();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
